// File: rtl/bpu_update_queue.sv
// Commit-side update queue for the branch predictor: compacts up to COMMIT_WIDTH
// resolved control-flow instructions per cycle into a FIFO and drains one per cycle.
package config_pkg;
    typedef struct packed {
        logic [31:0] PLEN;
    } cfg_t;

    localparam cfg_t EmptyCfg = '{PLEN: 32'd32};
endpackage

module bpu_update_queue #(
    parameter config_pkg::cfg_t Cfg = config_pkg::EmptyCfg,
    parameter int unsigned COMMIT_WIDTH = 4,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned PLEN = Cfg.PLEN,
    localparam int unsigned CW = $clog2(DEPTH + 1)
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [COMMIT_WIDTH-1:0]             commit_valid_i,
    input  logic [COMMIT_WIDTH-1:0][PLEN-1:0]   commit_pc_i,
    input  logic [COMMIT_WIDTH-1:0]             commit_is_cond_i,
    input  logic [COMMIT_WIDTH-1:0]             commit_taken_i,
    input  logic [COMMIT_WIDTH-1:0][PLEN-1:0]   commit_target_i,
    input  logic [COMMIT_WIDTH-1:0]             commit_is_call_i,
    input  logic [COMMIT_WIDTH-1:0]             commit_is_ret_i,
    output logic                                commit_ready_o,
    output logic                                update_valid_o,
    output logic [PLEN-1:0]                     update_pc_o,
    output logic                                update_is_cond_o,
    output logic                                update_taken_o,
    output logic [PLEN-1:0]                     update_target_o,
    output logic                                update_is_call_o,
    output logic                                update_is_ret_o,
    output logic [CW-1:0]                       count_o
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] PTR_MASK = PW'(DEPTH - 1);
    localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - COMMIT_WIDTH);

    typedef struct packed {
        logic [PLEN-1:0] pc;
        logic            is_cond;
        logic            taken;
        logic [PLEN-1:0] target;
        logic            is_call;
        logic            is_ret;
    } entry_t;

    entry_t        mem [DEPTH];
    logic [PW-1:0] head_q;
    logic [PW-1:0] tail_q;
    logic [CW-1:0] count_q;

    logic          ready;
    logic          pop;
    logic [CW-1:0] n_push;
    logic [CW-1:0] n_accept;
    logic [CW:0]   count_next_wide;
    logic [PW-1:0] slot [COMMIT_WIDTH];
    entry_t        lane_entry [COMMIT_WIDTH];
    entry_t        head_entry;

    // Conditional branches are never calls/returns; unconditional transfers are always taken.
    function automatic entry_t normalize(
        input logic [PLEN-1:0] pc,
        input logic            is_cond,
        input logic            taken,
        input logic [PLEN-1:0] target,
        input logic            is_call,
        input logic            is_ret
    );
        entry_t e;
        e.pc      = pc;
        e.is_cond = is_cond;
        e.taken   = is_cond ? taken : 1'b1;
        e.target  = target;
        e.is_call = !is_cond && is_call;
        e.is_ret  = !is_cond && is_ret && !is_call;
        return e;
    endfunction

    // Ready looks only at the registered count, so a same-cycle pop never feeds back into commit.
    assign ready = (count_q <= READY_MAX);
    assign pop   = (count_q != '0);

    // Each valid lane lands at tail plus the number of valid lanes below it.
    always_comb begin
        n_push = '0;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            slot[i]       = (tail_q + PW'(n_push)) & PTR_MASK;
            lane_entry[i] = normalize(commit_pc_i[i], commit_is_cond_i[i], commit_taken_i[i],
                                      commit_target_i[i], commit_is_call_i[i], commit_is_ret_i[i]);
            n_push        = n_push + CW'(commit_valid_i[i]);
        end
    end

    assign n_accept        = ready ? n_push : '0;
    assign count_next_wide = {1'b0, count_q} + {1'b0, n_accept} - (CW + 1)'(pop);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            tail_q  <= (tail_q + PW'(n_accept)) & PTR_MASK;
            if (pop) begin
                head_q <= (head_q + PW'(1)) & PTR_MASK;
            end
            count_q <= count_next_wide[CW-1:0];
        end
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            if (ready && commit_valid_i[i]) begin
                mem[slot[i]] <= lane_entry[i];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (count_next_wide <= (CW + 1)'(DEPTH));
        end
    end

    assign head_entry       = pop ? mem[head_q] : '0;
    assign commit_ready_o   = ready;
    assign update_valid_o   = pop;
    assign update_pc_o      = head_entry.pc;
    assign update_is_cond_o = head_entry.is_cond;
    assign update_taken_o   = head_entry.taken;
    assign update_target_o  = head_entry.target;
    assign update_is_call_o = head_entry.is_call;
    assign update_is_ret_o  = head_entry.is_ret;
    assign count_o          = count_q;
endmodule

// File: tb/tb_bpu_update_queue.sv
// Directed bench for bpu_update_queue: expected updates queue up when a group is
// accepted, and a negedge monitor pops and compares every presented update.
module tb_bpu_update_queue;
    localparam int W = 4;
    localparam int EW = 68;

    logic             clk = 1'b0;
    logic             rst;
    logic [W-1:0]     commit_valid;
    logic [W-1:0][31:0] commit_pc;
    logic [W-1:0]     commit_is_cond;
    logic [W-1:0]     commit_taken;
    logic [W-1:0][31:0] commit_target;
    logic [W-1:0]     commit_is_call;
    logic [W-1:0]     commit_is_ret;
    logic             commit_ready;
    logic             update_valid;
    logic [31:0]      update_pc;
    logic             update_is_cond;
    logic             update_taken;
    logic [31:0]      update_target;
    logic             update_is_call;
    logic             update_is_ret;
    logic [3:0]       count;

    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] pend_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    int n_pops   = 0;
    bit hold_mon = 1'b1;

    bpu_update_queue dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .commit_valid_i   (commit_valid),
        .commit_pc_i      (commit_pc),
        .commit_is_cond_i (commit_is_cond),
        .commit_taken_i   (commit_taken),
        .commit_target_i  (commit_target),
        .commit_is_call_i (commit_is_call),
        .commit_is_ret_i  (commit_is_ret),
        .commit_ready_o   (commit_ready),
        .update_valid_o   (update_valid),
        .update_pc_o      (update_pc),
        .update_is_cond_o (update_is_cond),
        .update_taken_o   (update_taken),
        .update_target_o  (update_target),
        .update_is_call_o (update_is_call),
        .update_is_ret_o  (update_is_ret),
        .count_o          (count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [EW-1:0] ent(input logic [31:0] pc, input logic cond, input logic taken,
                                          input logic [31:0] tgt, input logic call, input logic ret);
        return {pc, cond, taken, tgt, call, ret};
    endfunction

    task automatic chk(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: every valid update must match the oldest expected entry; idle outputs must be zero.
    always @(negedge clk) begin
        if (!hold_mon && !rst) begin
            if (update_valid) begin
                n_pops++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL update_unexpected: got pc %0h expected no update", update_pc);
                end else begin
                    chk("update_entry", {update_pc, update_is_cond, update_taken, update_target,
                                         update_is_call, update_is_ret}, exp_q.pop_front());
                end
            end else begin
                chk("idle_outputs_zero", {update_pc, update_is_cond, update_taken, update_target,
                                          update_is_call, update_is_ret}, '0);
            end
        end
    end

    task automatic clear_lanes();
        commit_valid   = '0;
        commit_pc      = '0;
        commit_is_cond = '0;
        commit_taken   = '0;
        commit_target  = '0;
        commit_is_call = '0;
        commit_is_ret  = '0;
    endtask

    task automatic set_lane(input int lane, input logic [31:0] pc, input logic cond, input logic taken,
                            input logic [31:0] tgt, input logic call, input logic ret);
        commit_valid[lane]   = 1'b1;
        commit_pc[lane]      = pc;
        commit_is_cond[lane] = cond;
        commit_taken[lane]   = taken;
        commit_target[lane]  = tgt;
        commit_is_call[lane] = call;
        commit_is_ret[lane]  = ret;
    endtask

    task automatic flush_pend();
        while (pend_q.size() != 0) exp_q.push_back(pend_q.pop_front());
    endtask

    // Holds the driven group until ready is seen; returns one cycle-step after the accepting edge.
    task automatic send_group(input string name, output int waited);
        bit ok = 1'b0;
        waited = 0;
        while (!ok && waited < 64) begin
            @(negedge clk);
            if (commit_ready) ok = 1'b1;
            else waited++;
        end
        if (!ok) begin
            n_checks++;
            $display("FAIL %s_accept: got no ready within 64 cycles expected acceptance", name);
            pend_q.delete();
        end else begin
            flush_pend();
        end
        @(posedge clk); #1;
        clear_lanes();
    endtask

    task automatic drain(input string name);
        int c = 0;
        @(negedge clk);
        while (update_valid && c < 100) begin
            @(negedge clk);
            c++;
        end
        chk({name, "_drained_valid"}, EW'(update_valid), '0);
        chk({name, "_drained_count"}, EW'(count), '0);
        chk({name, "_exp_empty"}, EW'(exp_q.size()), '0);
        @(posedge clk); #1;
    endtask

    task automatic load_full(input logic [31:0] base);
        for (int i = 0; i < W; i++) begin
            set_lane(i, base + 32'(4 * i), 1'b1, i[0], base + 32'h100 + 32'(i), 1'b0, 1'b0);
            pend_q.push_back(ent(base + 32'(4 * i), 1'b1, i[0], base + 32'h100 + 32'(i), 1'b0, 1'b0));
        end
    endtask

    initial begin
        int waited;
        int pops_start;
        logic [3:0] masks [8];
        int k;

        rst = 1'b1;
        clear_lanes();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        hold_mon = 1'b0;

        // Idle after reset
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_valid", EW'(update_valid), '0);
            chk("idle_ready", EW'(commit_ready), EW'(1));
            chk("idle_count", EW'(count), '0);
        end
        @(posedge clk); #1;

        // Single push on lane 2
        set_lane(2, 32'h8000_0010, 1'b1, 1'b1, 32'h8000_0100, 1'b0, 1'b0);
        pend_q.push_back(ent(32'h8000_0010, 1'b1, 1'b1, 32'h8000_0100, 1'b0, 1'b0));
        send_group("single", waited);
        @(negedge clk);
        chk("single_count", EW'(count), EW'(1));
        chk("single_valid", EW'(update_valid), EW'(1));
        @(negedge clk);
        chk("single_after_valid", EW'(update_valid), '0);
        chk("single_after_count", EW'(count), '0);
        @(posedge clk); #1;

        // Compaction: lanes 0 and 3
        set_lane(0, 32'h100, 1'b1, 1'b0, 32'h180, 1'b0, 1'b0);
        set_lane(3, 32'h10C, 1'b1, 1'b1, 32'h190, 1'b0, 1'b0);
        pend_q.push_back(ent(32'h100, 1'b1, 1'b0, 32'h180, 1'b0, 1'b0));
        pend_q.push_back(ent(32'h10C, 1'b1, 1'b1, 32'h190, 1'b0, 1'b0));
        send_group("compact", waited);
        @(negedge clk);
        chk("compact_count0", EW'(count), EW'(2));
        @(negedge clk);
        chk("compact_no_bubble", EW'(update_valid), EW'(1));
        chk("compact_count1", EW'(count), EW'(1));
        drain("compact");

        // Back-pressure with four full groups
        pops_start = n_pops;
        load_full(32'h2000);
        @(negedge clk);
        chk("bp_ready0", EW'(commit_ready), EW'(1));
        chk("bp_count0", EW'(count), '0);
        flush_pend();
        @(posedge clk); #1;
        load_full(32'h2010);
        @(negedge clk);
        chk("bp_count1", EW'(count), EW'(4));
        chk("bp_ready1", EW'(commit_ready), EW'(1));
        flush_pend();
        @(posedge clk); #1;
        load_full(32'h2020);
        @(negedge clk);
        chk("bp_count2", EW'(count), EW'(7));
        chk("bp_ready2", EW'(commit_ready), '0);
        send_group("bp_c", waited);
        chk("bp_c_wait", EW'(waited), EW'(2));
        load_full(32'h2030);
        send_group("bp_d", waited);
        chk("bp_d_wait", EW'(waited), EW'(3));
        drain("bp");
        chk("bp_pops", EW'(n_pops - pops_start), EW'(16));

        // Normalisation
        set_lane(0, 32'h200, 1'b0, 1'b0, 32'h300, 1'b1, 1'b0);
        set_lane(1, 32'h204, 1'b1, 1'b1, 32'h280, 1'b0, 1'b1);
        set_lane(2, 32'h208, 1'b0, 1'b0, 32'h500, 1'b1, 1'b1);
        set_lane(3, 32'h20C, 1'b0, 1'b1, 32'h600, 1'b0, 1'b1);
        pend_q.push_back(ent(32'h200, 1'b0, 1'b1, 32'h300, 1'b1, 1'b0));
        pend_q.push_back(ent(32'h204, 1'b1, 1'b1, 32'h280, 1'b0, 1'b0));
        pend_q.push_back(ent(32'h208, 1'b0, 1'b1, 32'h500, 1'b1, 1'b0));
        pend_q.push_back(ent(32'h20C, 1'b0, 1'b1, 32'h600, 1'b0, 1'b1));
        send_group("norm", waited);
        drain("norm");

        // Twenty entries across the pointer wrap
        masks = '{4'b0101, 4'b1110, 4'b1111, 4'b1000, 4'b0011, 4'b1111, 4'b0110, 4'b1001};
        k = 0;
        pops_start = n_pops;
        for (int g = 0; g < 8; g++) begin
            for (int l = 0; l < W; l++) begin
                if (masks[g][l]) begin
                    set_lane(l, 32'h1000 + 32'(4 * k), k[0], k[1], 32'h1040 + 32'(4 * k), 1'b0, 1'b0);
                    pend_q.push_back(ent(32'h1000 + 32'(4 * k), k[0], k[0] ? k[1] : 1'b1,
                                         32'h1040 + 32'(4 * k), 1'b0, 1'b0));
                    k++;
                end
            end
            send_group("wrap", waited);
        end
        drain("wrap");
        chk("wrap_pops", EW'(n_pops - pops_start), EW'(20));

        // Reset with three entries queued
        set_lane(0, 32'h3000, 1'b1, 1'b1, 32'h3100, 1'b0, 1'b0);
        set_lane(1, 32'h3004, 1'b1, 1'b0, 32'h3104, 1'b0, 1'b0);
        set_lane(2, 32'h3008, 1'b0, 1'b0, 32'h3108, 1'b1, 1'b0);
        send_group("rst_fill", waited);
        hold_mon = 1'b1;
        exp_q.delete();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_prefill_count", EW'(count), EW'(3));
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", EW'(update_valid), '0);
        chk("rst_count", EW'(count), '0);
        chk("rst_ready", EW'(commit_ready), EW'(1));
        chk("rst_outputs", {update_pc, update_is_cond, update_taken, update_target,
                            update_is_call, update_is_ret}, '0);
        hold_mon = 1'b0;
        @(posedge clk); #1;
        drain("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
